// File: rtl/prgrom_load_arb.sv
// -----------------------------------------------------------------------------
// prgrom_load_arb
//
// Arbitrates the program ROM port between the CPU instruction fetch and a
// byte-serial program loader.
//
// In normal operation (RUN) the CPU fetch address passes straight through to
// the ROM.
//
// When load_req rises (edge re-armed), the block does the following:
//   - stalls the CPU for one drain cycle;
//   - collects loader bytes into little-endian 32-bit words;
//   - writes each completed word at an incrementing address.
//
// When load_req falls, any partial word is zero-padded and written. The block
// then signals completion, which also requests a CPU restart at PC 0.
//
// Optional feature macro: PRGROM_LOAD_CHECKSUM_EN
//   When defined, adds a 32-bit `checksum` output. It holds the mod-2^32 sum
//   of all words written during the current or last load.
//
// Parameters
//   ADDR_W   ROM word-address width
//   WORDS    ROM capacity in words (a load stops once this many are written)
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   load_req       level request for program-load mode
//   byte_valid     loader byte valid
//   byte_data      loader byte
//   byte_ready     block accepts a byte this cycle
//   cpu_rom_adr    CPU fetch word address
//   rom_adr        ROM address port
//   rom_wdata      ROM write data
//   rom_we         ROM write enable
//   cpu_stall      freezes CPU PC and writeback
//   cpu_reset_req  forces CPU restart at PC 0
//   load_done      one-cycle completion pulse
//   word_count     words written in the current or last load
//   checksum       (PRGROM_LOAD_CHECKSUM_EN only) sum of written words
// -----------------------------------------------------------------------------
module prgrom_load_arb #(
  parameter int ADDR_W = 14,
  parameter int WORDS  = 16384
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_rom_adr,
  output logic [ADDR_W-1:0] rom_adr,
  output logic [31:0]       rom_wdata,
  output logic              rom_we,
  output logic              cpu_stall,
  output logic              cpu_reset_req,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count
`ifdef PRGROM_LOAD_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WC_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   WORDS_C = (ADDR_W + 1)'(WORDS);

  // Merge a byte into lane `lane` of a word; the first byte lands in [7:0].
  function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      2'd3:    res[31:24] = data;
      default: res        = word;
    endcase
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              armed_q, armed_d;
  // Set when the word being written is the last one of this load because
  // load_req already fell.
  logic              finish_q, finish_d;
  logic              accept_s;
  logic [ADDR_W:0]   wc_inc_s;
`ifdef PRGROM_LOAD_CHECKSUM_EN
  logic [31:0]       checksum_q, checksum_d;
`endif

  assign accept_s = (state_q == ST_COLLECT) && byte_valid;
  assign wc_inc_s = word_count_q + WC_ONE;

  // State register and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      ptr_q        <= '0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 32'd0;
      word_count_q <= '0;
      armed_q      <= 1'b1;
      finish_q     <= 1'b0;
`ifdef PRGROM_LOAD_CHECKSUM_EN
      checksum_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
      armed_q      <= armed_d;
      finish_q     <= finish_d;
`ifdef PRGROM_LOAD_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    word_count_d = word_count_q;
    finish_d     = finish_q;
`ifdef PRGROM_LOAD_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    // Any cycle with load_req low re-arms the start edge. The arm is consumed
    // when a load starts, so a request held through DONE cannot restart.
    armed_d      = armed_q | ~load_req;

    case (state_q)
      ST_RUN: begin
        if (load_req && armed_q) begin
          state_d      = ST_DRAIN;
          armed_d      = 1'b0;
          ptr_d        = '0;
          byte_cnt_d   = 2'd0;
          asm_d        = 32'd0;
          word_count_d = '0;
          finish_d     = 1'b0;
`ifdef PRGROM_LOAD_CHECKSUM_EN
          checksum_d   = 32'd0;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end

      // One stall cycle lets the CPU's in-flight fetch complete.
      ST_DRAIN: begin
        state_d = ST_COLLECT;
      end

      ST_COLLECT: begin
        if (accept_s) begin
          asm_d      = pack_byte(asm_q, byte_cnt_q, byte_data);
          byte_cnt_d = byte_cnt_q + 2'd1;
        end else begin
          asm_d      = asm_q;
          byte_cnt_d = byte_cnt_q;
        end
        // The byte is taken first, then the fall of load_req is evaluated
        // against the updated byte count.
        if (accept_s && (byte_cnt_q == 2'd3)) begin
          state_d  = ST_WRITE;
          finish_d = ~load_req;
        end else if (!load_req) begin
          if (accept_s || (byte_cnt_q != 2'd0)) begin
            state_d  = ST_WRITE;
            finish_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end

      // Bytes above the collected count are still zero, which gives the pad.
      ST_WRITE: begin
        ptr_d        = ptr_q + PTR_ONE;
        word_count_d = wc_inc_s;
        asm_d        = 32'd0;
        byte_cnt_d   = 2'd0;
        finish_d     = 1'b0;
`ifdef PRGROM_LOAD_CHECKSUM_EN
        checksum_d   = checksum_q + asm_q;
`endif
        if (finish_q || (wc_inc_s == WORDS_C)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_DONE: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    rom_adr       = cpu_rom_adr;
    rom_wdata     = asm_q;
    rom_we        = 1'b0;
    cpu_stall     = 1'b0;
    byte_ready    = 1'b0;
    load_done     = 1'b0;
    cpu_reset_req = 1'b0;
    case (state_q)
      ST_RUN: begin
        cpu_stall = 1'b0;
      end
      ST_DRAIN: begin
        cpu_stall = 1'b1;
      end
      ST_COLLECT: begin
        cpu_stall  = 1'b1;
        byte_ready = 1'b1;
      end
      ST_WRITE: begin
        cpu_stall = 1'b1;
        rom_we    = 1'b1;
        rom_adr   = ptr_q;
      end
      ST_DONE: begin
        cpu_stall     = 1'b1;
        load_done     = 1'b1;
        cpu_reset_req = 1'b1;
      end
      default: begin
        cpu_stall = 1'b0;
      end
    endcase
  end

  assign word_count = word_count_q;
`ifdef PRGROM_LOAD_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_prgrom_load_arb.sv
module tb_prgrom_load_arb;

  localparam int ADDR_W = 14;
  localparam int WORDS  = 4;

  logic              clock;
  logic              reset;
  logic              load_req;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] cpu_rom_adr;
  logic [ADDR_W-1:0] rom_adr;
  logic [31:0]       rom_wdata;
  logic              rom_we;
  logic              cpu_stall;
  logic              cpu_reset_req;
  logic              load_done;
  logic [ADDR_W:0]   word_count;
`ifdef PRGROM_LOAD_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int tests_run = 0;
  int failed    = 0;
  int wr_cnt    = 0;
  int done_cnt  = 0;
  logic [ADDR_W-1:0] wr_adr_log [32];
  logic [31:0]       wr_data_log [32];

  prgrom_load_arb #(.ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
    .clock(clock), .reset(reset), .load_req(load_req),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .cpu_rom_adr(cpu_rom_adr), .rom_adr(rom_adr), .rom_wdata(rom_wdata),
    .rom_we(rom_we), .cpu_stall(cpu_stall), .cpu_reset_req(cpu_reset_req),
    .load_done(load_done), .word_count(word_count)
`ifdef PRGROM_LOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log every ROM write and completion pulse, sampled mid-cycle.
  always @(negedge clock) begin
    if (rom_we === 1'b1) begin
      if (wr_cnt < 32) begin
        wr_adr_log[wr_cnt]  <= rom_adr;
        wr_data_log[wr_cnt] <= rom_wdata;
      end
      wr_cnt <= wr_cnt + 1;
    end
    if (load_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_req = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    cpu_rom_adr = '0;
    tick(); tick();
    tests_run++; if (rom_we !== 1'b0) begin failed++; $display("FAIL reset_rom_we got %0b want 0", rom_we); end
    tests_run++; if (cpu_stall !== 1'b0) begin failed++; $display("FAIL reset_cpu_stall got %0b want 0", cpu_stall); end
    tests_run++; if (byte_ready !== 1'b0) begin failed++; $display("FAIL reset_byte_ready got %0b want 0", byte_ready); end
    tests_run++; if (load_done !== 1'b0 || cpu_reset_req !== 1'b0) begin failed++; $display("FAIL reset_done_req got %0b/%0b want 0/0", load_done, cpu_reset_req); end
    tests_run++; if (word_count !== 15'd0) begin failed++; $display("FAIL reset_word_count got %0d want 0", word_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_idle();
    cpu_rom_adr = 14'h0123;
    #1;
    tests_run++; if (rom_adr !== 14'h0123) begin failed++; $display("FAIL idle_rom_adr got %h want 0123", rom_adr); end
    tests_run++; if (rom_we !== 1'b0 || cpu_stall !== 1'b0) begin failed++; $display("FAIL idle_we_stall got %0b/%0b want 0/0", rom_we, cpu_stall); end
    tick();
    tests_run++; if (cpu_stall !== 1'b0 || byte_ready !== 1'b0) begin failed++; $display("FAIL idle_hold got stall %0b ready %0b want 0/0", cpu_stall, byte_ready); end
  endtask

  task automatic test_one_word();
    int wr0, dn0;
    logic [7:0] bytes [4];
    bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
    wr0 = wr_cnt; dn0 = done_cnt;
    load_req = 1'b1;
    tick(); // DRAIN
    tests_run++; if (cpu_stall !== 1'b1 || byte_ready !== 1'b0) begin failed++; $display("FAIL one_drain got stall %0b ready %0b want 1/0", cpu_stall, byte_ready); end
    tests_run++; if (rom_adr !== 14'h0123) begin failed++; $display("FAIL one_drain_adr got %h want 0123", rom_adr); end
    tick(); // COLLECT
    tests_run++; if (byte_ready !== 1'b1 || cpu_stall !== 1'b1) begin failed++; $display("FAIL one_collect got ready %0b stall %0b want 1/1", byte_ready, cpu_stall); end
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1; byte_data = bytes[i];
      tick();
    end
    byte_valid = 1'b0;
    // now in WRITE; load_req falls here and must be ignored until COLLECT
    load_req = 1'b0;
    tests_run++; if (rom_we !== 1'b1 || rom_adr !== 14'h0000 || rom_wdata !== 32'h12345678) begin failed++; $display("FAIL one_write got we %0b adr %h data %h want 1/0000/12345678", rom_we, rom_adr, rom_wdata); end
    tests_run++; if (byte_ready !== 1'b0 || cpu_stall !== 1'b1) begin failed++; $display("FAIL one_write_ctl got ready %0b stall %0b want 0/1", byte_ready, cpu_stall); end
    tick(); // COLLECT
    tests_run++; if (rom_we !== 1'b0 || word_count !== 15'd1 || cpu_stall !== 1'b1) begin failed++; $display("FAIL one_after_write got we %0b wc %0d stall %0b want 0/1/1", rom_we, word_count, cpu_stall); end
    tick(); // DONE
    tests_run++; if (load_done !== 1'b1 || cpu_reset_req !== 1'b1 || cpu_stall !== 1'b1) begin failed++; $display("FAIL one_done got done %0b rreq %0b stall %0b want 1/1/1", load_done, cpu_reset_req, cpu_stall); end
    tick(); // RUN
    tests_run++; if (load_done !== 1'b0 || cpu_stall !== 1'b0 || cpu_reset_req !== 1'b0) begin failed++; $display("FAIL one_run got done %0b stall %0b rreq %0b want 0/0/0", load_done, cpu_stall, cpu_reset_req); end
    tick(); tick();
    tests_run++; if (word_count !== 15'd1) begin failed++; $display("FAIL one_wc_hold got %0d want 1", word_count); end
    tests_run++; if (wr_cnt - wr0 !== 1 || done_cnt - dn0 !== 1) begin failed++; $display("FAIL one_counts got writes %0d dones %0d want 1/1", wr_cnt - wr0, done_cnt - dn0); end
    tests_run++; if (wr_adr_log[wr0] !== 14'h0000 || wr_data_log[wr0] !== 32'h12345678) begin failed++; $display("FAIL one_log got %h@%h want 12345678@0000", wr_data_log[wr0], wr_adr_log[wr0]); end
  endtask

  task automatic test_partial();
    int wr0, dn0;
    wr0 = wr_cnt; dn0 = done_cnt;
    load_req = 1'b1;
    tick(); tick(); // DRAIN, COLLECT
    for (int i = 1; i <= 4; i++) begin
      byte_valid = 1'b1; byte_data = 8'(i);
      tick();
    end
    byte_valid = 1'b0;
    tests_run++; if (rom_we !== 1'b1 || rom_adr !== 14'h0000 || rom_wdata !== 32'h04030201) begin failed++; $display("FAIL part_w0 got we %0b adr %h data %h want 1/0000/04030201", rom_we, rom_adr, rom_wdata); end
    tick(); // COLLECT
    byte_valid = 1'b1; byte_data = 8'h05;
    tick();
    // sixth byte and load_req fall in the same cycle: byte taken first
    byte_data = 8'h06; load_req = 1'b0;
    tick();
    byte_valid = 1'b0;
    tests_run++; if (rom_we !== 1'b1 || rom_adr !== 14'h0001 || rom_wdata !== 32'h00000605) begin failed++; $display("FAIL part_w1 got we %0b adr %h data %h want 1/0001/00000605", rom_we, rom_adr, rom_wdata); end
    tick(); // DONE directly
    tests_run++; if (load_done !== 1'b1 || word_count !== 15'd2) begin failed++; $display("FAIL part_done got done %0b wc %0d want 1/2", load_done, word_count); end
    tick(); // RUN
    tests_run++; if (wr_cnt - wr0 !== 2 || done_cnt - dn0 !== 1) begin failed++; $display("FAIL part_counts got writes %0d dones %0d want 2/1", wr_cnt - wr0, done_cnt - dn0); end
    tests_run++; if (wr_data_log[wr0 + 1] !== 32'h00000605 || wr_adr_log[wr0 + 1] !== 14'h0001) begin failed++; $display("FAIL part_log got %h@%h want 00000605@0001", wr_data_log[wr0 + 1], wr_adr_log[wr0 + 1]); end
  endtask

  task automatic test_full_rom();
    int wr0, dn0;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h03020100; exp_w[1] = 32'h07060504;
    exp_w[2] = 32'h0B0A0908; exp_w[3] = 32'h0F0E0D0C;
    wr0 = wr_cnt; dn0 = done_cnt;
    load_req = 1'b1;
    tick(); tick();
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) begin
        byte_valid = 1'b1; byte_data = 8'(w * 4 + b);
        tick();
      end
      byte_valid = 1'b0;
      tests_run++; if (rom_we !== 1'b1 || rom_adr !== 14'(w) || rom_wdata !== exp_w[w]) begin failed++; $display("FAIL full_w%0d got we %0b adr %h data %h want 1/%h/%h", w, rom_we, rom_adr, rom_wdata, 14'(w), exp_w[w]); end
      tick();
    end
    // DONE with load_req still high
    tests_run++; if (load_done !== 1'b1 || word_count !== 15'd4) begin failed++; $display("FAIL full_done got done %0b wc %0d want 1/4", load_done, word_count); end
    tick(); // RUN; request still high must not restart
    byte_valid = 1'b1; byte_data = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (cpu_stall !== 1'b0 || byte_ready !== 1'b0) begin failed++; $display("FAIL full_norearm%0d got stall %0b ready %0b want 0/0", i, cpu_stall, byte_ready); end
      tick();
    end
    byte_valid = 1'b0;
    tests_run++; if (wr_cnt - wr0 !== 4 || done_cnt - dn0 !== 1 || word_count !== 15'd4) begin failed++; $display("FAIL full_counts got writes %0d dones %0d wc %0d want 4/1/4", wr_cnt - wr0, done_cnt - dn0, word_count); end
    load_req = 1'b0; tick();
    load_req = 1'b1; tick();
    tests_run++; if (cpu_stall !== 1'b1 || word_count !== 15'd0) begin failed++; $display("FAIL full_rearm got stall %0b wc %0d want 1/0", cpu_stall, word_count); end
  endtask

  // Continues from the DRAIN entered at the end of test_full_rom.
  task automatic test_reset_mid_load();
    int wr0, dn0;
    wr0 = wr_cnt; dn0 = done_cnt;
    tick(); // COLLECT
    byte_valid = 1'b1; byte_data = 8'h11; tick();
    byte_data = 8'h22; tick();
    byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    tests_run++; if (rom_we !== 1'b0 || cpu_stall !== 1'b0 || byte_ready !== 1'b0) begin failed++; $display("FAIL rst_mid_outs got we %0b stall %0b ready %0b want 0/0/0", rom_we, cpu_stall, byte_ready); end
    tests_run++; if (load_done !== 1'b0 || cpu_reset_req !== 1'b0 || word_count !== 15'd0) begin failed++; $display("FAIL rst_mid_done got done %0b rreq %0b wc %0d want 0/0/0", load_done, cpu_reset_req, word_count); end
    reset = 1'b0;
    tick(); // load_req held high through reset starts a load
    tests_run++; if (wr_cnt - wr0 !== 0 || done_cnt - dn0 !== 0) begin failed++; $display("FAIL rst_mid_counts got writes %0d dones %0d want 0/0", wr_cnt - wr0, done_cnt - dn0); end
    tests_run++; if (cpu_stall !== 1'b1 || byte_ready !== 1'b0) begin failed++; $display("FAIL rst_rearm got stall %0b ready %0b want 1/0", cpu_stall, byte_ready); end
    tick(); // COLLECT
    load_req = 1'b0;
    tick(); // DONE with no bytes
    tests_run++; if (load_done !== 1'b1 || word_count !== 15'd0) begin failed++; $display("FAIL rst_empty_done got done %0b wc %0d want 1/0", load_done, word_count); end
    tick();
    tests_run++; if (wr_cnt - wr0 !== 0) begin failed++; $display("FAIL rst_empty_writes got %0d want 0", wr_cnt - wr0); end
  endtask

`ifdef PRGROM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] bytes [8];
    bytes[0] = 8'hFF; bytes[1] = 8'hFF; bytes[2] = 8'hFF; bytes[3] = 8'hFF;
    bytes[4] = 8'h02; bytes[5] = 8'h00; bytes[6] = 8'h00; bytes[7] = 8'h00;
    load_req = 1'b1;
    tick(); tick();
    tests_run++; if (checksum !== 32'd0) begin failed++; $display("FAIL cks_clear got %h want 00000000", checksum); end
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1; byte_data = bytes[i];
      tick();
      if (i == 3) begin
        byte_valid = 1'b0;
        tick();
      end
    end
    byte_valid = 1'b0; load_req = 1'b0;
    tick(); // COLLECT
    tick(); // DONE
    tests_run++; if (load_done !== 1'b1 || checksum !== 32'h00000001) begin failed++; $display("FAIL cks_done got done %0b cks %h want 1/00000001", load_done, checksum); end
    tick();
    tests_run++; if (checksum !== 32'h00000001 || word_count !== 15'd2) begin failed++; $display("FAIL cks_hold got cks %h wc %0d want 00000001/2", checksum, word_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_one_word();
    test_partial();
    test_full_rom();
    test_reset_mid_load();
`ifdef PRGROM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
